// File: rtl/pulse_pair_meter.sv
// Purpose: synchronise and de-glitch a raw RF input, then measure each high/low pulse pair in clk cycles.
// Latency: detected asserts SYNC_STAGES+GLITCH cycles after the clk edge that samples the terminating rise.
// Backpressure: none; each report is a one-cycle strobe and the count outputs hold until the next report.
module pulse_pair_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH      = 3,
    parameter int MAX_LOW     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    output logic [CNT_W-1:0] count_h,
    output logic [CNT_W-1:0] count_l,
    output logic             detected,
    output logic             gap,
    output logic             sat
);

    localparam int RUN_W = (GLITCH > 1) ? $clog2(GLITCH) : 1;

    localparam logic [1:0] ST_WAIT_RISE = 2'd0;
    localparam logic [1:0] ST_HIGH      = 2'd1;
    localparam logic [1:0] ST_LOW       = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_LOW_C = CNT_W'(MAX_LOW);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(GLITCH - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   filt;
    logic                   filt_d;
    logic [RUN_W-1:0]       run_cnt;
    logic                   rise;
    logic                   fall;
    logic                   timeout_hit;

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt_h;
    logic [CNT_W-1:0]       cnt_l;
    logic                   sat_i;

    assign s           = sync_q[SYNC_STAGES-1];
    assign rise        = filt & ~filt_d;
    assign fall        = ~filt & filt_d;
    assign timeout_hit = (MAX_LOW != 0) && (cnt_l == MAX_LOW_C);

    // Synchroniser and persistence filter run regardless of en so f is settled when measuring resumes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            filt    <= 1'b0;
            filt_d  <= 1'b0;
            run_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            filt_d <= filt;
            if (s == filt) begin
                run_cnt <= '0;
            end else if (run_cnt == RUN_LAST) begin
                filt    <= s;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_WAIT_RISE;
            cnt_h    <= '0;
            cnt_l    <= '0;
            sat_i    <= 1'b0;
            count_h  <= '0;
            count_l  <= '0;
            detected <= 1'b0;
            gap      <= 1'b0;
            sat      <= 1'b0;
        end else begin
            detected <= 1'b0;
            if (!en) begin
                state <= ST_WAIT_RISE;
                cnt_h <= '0;
                cnt_l <= '0;
                sat_i <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_RISE: begin
                        if (rise) begin
                            cnt_h <= CNT_ONE;
                            sat_i <= 1'b0;
                            state <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            cnt_l <= CNT_ONE;
                            state <= ST_LOW;
                        end else if (filt) begin
                            if (cnt_h == CNT_MAX) sat_i <= 1'b1;
                            else                  cnt_h <= cnt_h + 1'b1;
                        end
                    end
                    ST_LOW: begin
                        // A rise coinciding with the timeout is a normal pair, not a sync gap.
                        if (rise) begin
                            count_h  <= cnt_h;
                            count_l  <= cnt_l;
                            gap      <= 1'b0;
                            sat      <= sat_i;
                            detected <= 1'b1;
                            cnt_h    <= CNT_ONE;
                            sat_i    <= 1'b0;
                            state    <= ST_HIGH;
                        end else if (timeout_hit) begin
                            count_h  <= cnt_h;
                            count_l  <= cnt_l;
                            gap      <= 1'b1;
                            sat      <= sat_i;
                            detected <= 1'b1;
                            cnt_h    <= '0;
                            cnt_l    <= '0;
                            state    <= ST_WAIT_RISE;
                        end else if (!filt) begin
                            if (cnt_l == CNT_MAX) sat_i <= 1'b1;
                            else                  cnt_l <= cnt_l + 1'b1;
                        end
                    end
                    default: state <= ST_WAIT_RISE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_pair_meter.sv
// Bench for pulse_pair_meter: table of pulse shapes plus hand-written abort/timeout/saturation sequences.
module tb_pulse_pair_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_sig;
    logic        in4;
    logic [15:0] count_h;
    logic [15:0] count_l;
    logic        detected;
    logic        gap;
    logic        sat;
    logic [3:0]  count_h4;
    logic [3:0]  count_l4;
    logic        detected4;
    logic        gap4;
    logic        sat4;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int h;
        int l;
        bit gap;
        bit sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    exp_t mon_e;
    exp_t mon_e4;

    typedef struct {
        int h;
        int l;
        int sp_at;
        int sp_len;
        int n_rep;
        int e_h1;
        int e_l1;
        int e_h2;
        int e_l2;
    } vec_t;

    vec_t vecs[6];

    pulse_pair_meter #(.CNT_W(16), .SYNC_STAGES(2), .GLITCH(3), .MAX_LOW(200)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in_sig),
        .count_h(count_h), .count_l(count_l), .detected(detected), .gap(gap), .sat(sat)
    );

    // 4-bit instance; MAX_LOW must stay below 2**CNT_W.
    pulse_pair_meter #(.CNT_W(4), .SYNC_STAGES(2), .GLITCH(3), .MAX_LOW(12)) dut4 (
        .clk(clk), .rst(rst), .en(en), .in(in4),
        .count_h(count_h4), .count_l(count_l4), .detected(detected4), .gap(gap4), .sat(sat4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input longint expv);
        n_cmp++;
        if (act !== 64'(expv)) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int h, input int l, input bit g, input bit s, input int c, input bit ch4);
        exp_t e;
        e.h = h; e.l = l; e.gap = g; e.sat = s; e.cyc = c;
        if (ch4) q4.push_back(e);
        else     q.push_back(e);
    endtask

    // Holds a level for n sampling edges; called and returns #1 after a posedge.
    task automatic level(input logic v, input int n, input bit ch4);
        if (ch4) in4 = v;
        else     in_sig = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Terminating high, then abort via en so the next test starts from WAIT_RISE with f low.
    task automatic cleanup();
        level(1'b1, 6, 1'b0);
        en = 1'b0;
        level(1'b0, 10, 1'b0);
        en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (detected) begin
            if (q.size() == 0) begin
                check("spurious_detected", detected, 0);
            end else begin
                mon_e = q.pop_front();
                check("count_h", count_h, mon_e.h);
                check("count_l", count_l, mon_e.l);
                check("gap", gap, mon_e.gap);
                check("sat", sat, mon_e.sat);
                check("report_cycle", cyc, mon_e.cyc);
            end
        end
        if (detected4) begin
            if (q4.size() == 0) begin
                check("spurious_detected4", detected4, 0);
            end else begin
                mon_e4 = q4.pop_front();
                check("count_h4", count_h4, mon_e4.h);
                check("count_l4", count_l4, mon_e4.l);
                check("gap4", gap4, mon_e4.gap);
                check("sat4", sat4, mon_e4.sat);
                check("report_cycle4", cyc, mon_e4.cyc);
            end
        end
    end

    initial begin
        // h, l, spike start (low index), spike length, reports, expected pair 1, expected pair 2
        vecs[0] = '{10, 30,  0, 0, 1, 10,  30, 0,  0};
        vecs[1] = '{10, 30, 11, 2, 1, 10,  30, 0,  0};
        vecs[2] = '{10, 30, 11, 3, 2, 10,  11, 3, 16};
        vecs[3] = '{ 3,  3,  0, 0, 1,  3,   3, 0,  0};
        vecs[4] = '{ 4, 200, 0, 0, 1,  4, 200, 0,  0};
        vecs[5] = '{25,  9,  4, 1, 1, 25,   9, 0,  0};

        rst = 1'b0; en = 1'b1; in_sig = 1'b0; in4 = 1'b0;

        // Reset held while the input toggles.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_sig = ~in_sig;
            in4    = ~in4;
            @(negedge clk);
            check("rst_count_h", count_h, 0);
            check("rst_count_l", count_l, 0);
            check("rst_detected", {detected, detected4}, 0);
            check("rst_gap_sat", {gap, sat, gap4, sat4}, 0);
        end
        @(posedge clk); #1;
        in_sig = 1'b0; in4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        level(1'b0, 5, 1'b0);

        for (int v = 0; v < 6; v++) begin
            level(1'b1, vecs[v].h, 1'b0);
            if (vecs[v].sp_len == 0) begin
                level(1'b0, vecs[v].l, 1'b0);
            end else begin
                level(1'b0, vecs[v].sp_at, 1'b0);
                if (vecs[v].n_rep == 2) push(vecs[v].e_h1, vecs[v].e_l1, 0, 0, cyc + 6, 0);
                level(1'b1, vecs[v].sp_len, 1'b0);
                level(1'b0, vecs[v].l - vecs[v].sp_at - vecs[v].sp_len, 1'b0);
            end
            if (vecs[v].n_rep == 2) push(vecs[v].e_h2, vecs[v].e_l2, 0, 0, cyc + 6, 0);
            else                    push(vecs[v].e_h1, vecs[v].e_l1, 0, 0, cyc + 6, 0);
            cleanup();
            check("hold_count_l", count_l, (vecs[v].n_rep == 2) ? vecs[v].e_l2 : vecs[v].e_l1);
        end

        // Sync gap: low held past MAX_LOW, next rise only restarts measurement.
        level(1'b1, 10, 1'b0);
        push(10, 200, 1, 0, cyc + 1 + 200 + 5, 0);
        level(1'b0, 500, 1'b0);
        check("gap_held", gap, 1);
        level(1'b1, 8, 1'b0);
        level(1'b0, 12, 1'b0);
        push(8, 12, 0, 0, cyc + 6, 0);
        cleanup();
        check("gap_cleared", gap, 0);

        // en dropped mid-HIGH aborts the pair.
        level(1'b1, 5, 1'b0);
        en = 1'b0;
        level(1'b1, 5, 1'b0);
        level(1'b0, 10, 1'b0);
        en = 1'b1;
        level(1'b1, 8, 1'b0);
        level(1'b0, 12, 1'b0);
        push(8, 12, 0, 0, cyc + 6, 0);
        cleanup();

        // Reset asserted mid-LOW discards the partial pair; outputs clear.
        level(1'b1, 8, 1'b0);
        level(1'b0, 6, 1'b0);
        rst = 1'b0;
        level(1'b0, 3, 1'b0);
        check("midrst_count_h", count_h, 0);
        rst = 1'b1;
        level(1'b0, 10, 1'b0);
        level(1'b1, 8, 1'b0);
        level(1'b0, 12, 1'b0);
        push(8, 12, 0, 0, cyc + 6, 0);
        cleanup();

        // Saturation on the 4-bit instance, then a clean pair clears sat.
        level(1'b1, 20, 1'b1);
        level(1'b0, 5, 1'b1);
        push(15, 5, 0, 1, cyc + 6, 1);
        level(1'b1, 6, 1'b1);
        level(1'b0, 7, 1'b1);
        push(6, 7, 0, 0, cyc + 6, 1);
        level(1'b1, 20, 1'b1);
        check("hold_count_h4", count_h4, 6);
        check("hold_count_l4", count_l4, 7);
        check("hold_sat4", sat4, 0);

        level(1'b0, 10, 1'b0);
        check("pending_reports", q.size(), 0);
        check("pending_reports4", q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
